// File: rtl/nn_fixed_pkg.sv
// Shared fixed-point definitions for the neuron datapath: default Q8.8 geometry,
// saturation limits and the MAC sequencing states.
package nn_fixed_pkg;

   localparam int NN_DATA_W    = 16;
   localparam int NN_FRAC_BITS = 8;

   localparam logic [NN_DATA_W-1:0] SAT_MAX = 16'h7FFF;
   localparam logic [NN_DATA_W-1:0] SAT_MIN = 16'h8000;

   typedef enum logic [1:0] {
      ACC   = 2'd0,
      DRAIN = 2'd1,
      HOLD  = 2'd2
   } mac_state_e;

endpackage

// File: rtl/fixed_mul_sat.sv
// Combinational signed fixed-point multiply: full-width product, arithmetic shift
// by FRAC_BITS (floor), then clamp to DATA_W with a saturation flag.
module fixed_mul_sat
   import nn_fixed_pkg::*;
#(
   parameter int DATA_W    = NN_DATA_W,
   parameter int FRAC_BITS = NN_FRAC_BITS
) (
   input  logic [DATA_W-1:0] a_i,
   input  logic [DATA_W-1:0] b_i,
   output logic [DATA_W-1:0] prod_o,
   output logic              sat_o
);

   localparam int PW = 2 * DATA_W;
   localparam logic signed [PW-1:0] MAX_W = {{(DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
   localparam logic signed [PW-1:0] MIN_W = {{(DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

   logic signed [PW-1:0] full_s;
   logic signed [PW-1:0] shr_s;

   // Sign-extend both operands so the product is exact in PW bits, then clamp.
   always_comb begin
      full_s = $signed({{DATA_W{a_i[DATA_W-1]}}, a_i}) * $signed({{DATA_W{b_i[DATA_W-1]}}, b_i});
      shr_s  = full_s >>> FRAC_BITS;
      if (shr_s > MAX_W) begin
         prod_o = MAX_W[DATA_W-1:0];
         sat_o  = 1'b1;
      end else if (shr_s < MIN_W) begin
         prod_o = MIN_W[DATA_W-1:0];
         sat_o  = 1'b1;
      end else begin
         prod_o = shr_s[DATA_W-1:0];
         sat_o  = 1'b0;
      end
   end

endmodule

// File: rtl/mac_accumulator.sv
// Sequential saturating multiply-accumulate for one neuron: bias-seeded vectors in,
// one clamped result per vector out. Optional macro MAC_ACCUMULATOR_RELU_EN clamps
// negative results to zero at output load.
module mac_accumulator
   import nn_fixed_pkg::*;
#(
   parameter int DATA_W    = NN_DATA_W,
   parameter int FRAC_BITS = NN_FRAC_BITS
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_act,
   input  logic [DATA_W-1:0] in_wgt,
   input  logic [DATA_W-1:0] in_bias,
   input  logic              in_last,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_sat
);

   localparam int MSB = DATA_W - 1;
   localparam logic [DATA_W-1:0] MAX_C  = {1'b0, {(DATA_W-1){1'b1}}};
   localparam logic [DATA_W-1:0] MIN_C  = {1'b1, {(DATA_W-1){1'b0}}};
   localparam logic [DATA_W-1:0] ZERO_C = {DATA_W{1'b0}};

   mac_state_e        state_q, state_d;
   logic              in_ready_q, in_ready_d;
   logic              out_valid_q, out_valid_d;
   logic [DATA_W-1:0] out_data_q, out_data_d;
   logic              out_sat_q, out_sat_d;
   logic              mid_vec_q, mid_vec_d;
   logic              vec_sat_q, vec_sat_d;
   logic [DATA_W-1:0] acc_q, acc_d;

   logic              s1_valid_q, s1_first_q, s1_last_q, s1_sat_q;
   logic [DATA_W-1:0] s1_prod_q, s1_bias_q;

   logic              in_fire_s;
   logic [DATA_W-1:0] mul_prod_s;
   logic              mul_sat_s;
   logic [DATA_W-1:0] addend_s, sum_raw_s, sum_sat_s, result_s;
   logic              add_sat_s;

   assign in_fire_s = in_valid & in_ready_q;

   fixed_mul_sat #(
      .DATA_W    (DATA_W),
      .FRAC_BITS (FRAC_BITS)
   ) u_mul (
      .a_i    (in_act),
      .b_i    (in_wgt),
      .prod_o (mul_prod_s),
      .sat_o  (mul_sat_s)
   );

   // Stage 1: register the clamped product with its vector tags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q <= 1'b0;
         s1_first_q <= 1'b0;
         s1_last_q  <= 1'b0;
         s1_sat_q   <= 1'b0;
         s1_prod_q  <= ZERO_C;
         s1_bias_q  <= ZERO_C;
      end else begin
         s1_valid_q <= in_fire_s;
         if (in_fire_s) begin
            s1_first_q <= ~mid_vec_q;
            s1_last_q  <= in_last;
            s1_sat_q   <= mul_sat_s;
            s1_prod_q  <= mul_prod_s;
            s1_bias_q  <= mid_vec_q ? ZERO_C : in_bias;
         end
      end
   end

   // Stage 2: saturating add of the product onto the bias (first beat) or running sum.
   always_comb begin
      addend_s  = s1_first_q ? s1_bias_q : acc_q;
      sum_raw_s = addend_s + s1_prod_q;
      if (!addend_s[MSB] && !s1_prod_q[MSB] && sum_raw_s[MSB]) begin
         sum_sat_s = MAX_C;
         add_sat_s = 1'b1;
      end else if (addend_s[MSB] && s1_prod_q[MSB] && !sum_raw_s[MSB]) begin
         sum_sat_s = MIN_C;
         add_sat_s = 1'b1;
      end else begin
         sum_sat_s = sum_raw_s;
         add_sat_s = 1'b0;
      end
   end

`ifdef MAC_ACCUMULATOR_RELU_EN
   assign result_s = sum_sat_s[MSB] ? ZERO_C : sum_sat_s;
`else
   assign result_s = sum_sat_s;
`endif

   // Next-state and output-register logic for the ACC/DRAIN/HOLD sequencer.
   always_comb begin
      state_d     = state_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_sat_d   = out_sat_q;
      mid_vec_d   = mid_vec_q;
      vec_sat_d   = vec_sat_q;
      acc_d       = acc_q;

      if (s1_valid_q) begin
         acc_d     = sum_sat_s;
         vec_sat_d = vec_sat_q | s1_sat_q | add_sat_s;
      end else begin
         acc_d     = acc_q;
         vec_sat_d = vec_sat_q;
      end

      if (in_fire_s) begin
         mid_vec_d = 1'b1;
      end else begin
         mid_vec_d = mid_vec_q;
      end

      case (state_q)
         ACC: begin
            if (in_fire_s && in_last) begin
               state_d = DRAIN;
            end else begin
               state_d = ACC;
            end
         end
         DRAIN: begin
            if (s1_valid_q && s1_last_q) begin
               state_d     = HOLD;
               out_valid_d = 1'b1;
               out_data_d  = result_s;
               out_sat_d   = vec_sat_d;
            end else begin
               state_d = DRAIN;
            end
         end
         HOLD: begin
            if (out_ready) begin
               state_d     = ACC;
               out_valid_d = 1'b0;
               mid_vec_d   = 1'b0;
               vec_sat_d   = 1'b0;
            end else begin
               state_d = HOLD;
            end
         end
         default: begin
            state_d     = ACC;
            out_valid_d = 1'b0;
            mid_vec_d   = 1'b0;
            vec_sat_d   = 1'b0;
         end
      endcase

      in_ready_d = (state_d == ACC);
   end

   // Control, accumulator and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ACC;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= ZERO_C;
         out_sat_q   <= 1'b0;
         mid_vec_q   <= 1'b0;
         vec_sat_q   <= 1'b0;
         acc_q       <= ZERO_C;
      end else begin
         state_q     <= state_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_sat_q   <= out_sat_d;
         mid_vec_q   <= mid_vec_d;
         vec_sat_q   <= vec_sat_d;
         acc_q       <= acc_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_sat   = out_sat_q;

endmodule
